// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module : dmem_arb_pkg
// Brief  : Shared state encodings and port indices for the data-memory arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// Module : dmem_arbiter_if
// Brief  : Requester-side and memory-side signal bundle of the arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          lock1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    // Arbiter side
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock1, mem_rdata,
        output ack0, ack1, rdata, mem_addr, mem_wdata, mem_we, busy
    );

    // Requesters plus memory side
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock1, mem_rdata,
        input  ack0, ack1, rdata, mem_addr, mem_wdata, mem_we, busy
    );

endinterface

`default_nettype wire

// File: rtl/rr_pick2.sv
// ============================================================================
// Module : rr_pick2
// Brief  : Combinational two-way round-robin picker with a port-1 override.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    input  logic force1,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req0 | req1;
        winner = P0;
        if (req0 && req1) begin
            // Tie: the port not served last wins unless port 1 holds the bus
            winner = force1 ? P1 : ~last;
        end else if (req1) begin
            winner = P1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module : dmem_arbiter
// Brief  : Round-robin two-port arbiter and access sequencer for the data memory.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    localparam int LCW = $clog2(MAX_LOCK + 1);

    state_e         state_q;
    state_e         state_d;
    logic           sel_q;
    logic           we_q;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  wdata_q;
    logic [DW-1:0]  rdata_q;
    logic           last_grant_q;
    logic [LCW-1:0] lock_cnt_q;
    logic [LCW-1:0] lock_cnt_d;

    logic w_lock_active;
    logic w_valid;
    logic w_winner;
    logic w_take;

    assign w_lock_active = bus.lock1 && (last_grant_q == P1) &&
                           (lock_cnt_q < LCW'(MAX_LOCK));
    assign w_take        = (state_q == IDLE) && w_valid;

    rr_pick2 u_pick (
        .req0   (bus.req0),
        .req1   (bus.req1),
        .last   (last_grant_q),
        .force1 (w_lock_active),
        .valid  (w_valid),
        .winner (w_winner)
    );

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (!bus.lock1) begin
            lock_cnt_d = '0;
        end else if (w_take) begin
            if (w_winner == P0) begin
                lock_cnt_d = '0;
            end else if (w_lock_active) begin
                lock_cnt_d = lock_cnt_q + LCW'(1);
            end
        end
    end

    // Outputs decode straight from the state register so an async reset
    // kills mem_we and the acks without waiting for a clock edge.
    always_comb begin
        state_d       = state_q;
        bus.ack0      = 1'b0;
        bus.ack1      = 1'b0;
        bus.busy      = 1'b1;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.rdata     = rdata_q;
        unique case (state_q)
            IDLE: begin
                bus.busy = 1'b0;
                if (w_valid) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                bus.mem_we    = we_q;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
                state_d       = DONE;
            end
            DONE: begin
                bus.ack0 = (sel_q == P0);
                bus.ack1 = (sel_q == P1);
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= P0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            last_grant_q <= P1;
            lock_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            if (w_take) begin
                sel_q        <= w_winner;
                last_grant_q <= w_winner;
                we_q         <= (w_winner == P1) ? bus.we1    : bus.we0;
                addr_q       <= (w_winner == P1) ? bus.addr1  : bus.addr0;
                wdata_q      <= (w_winner == P1) ? bus.wdata1 : bus.wdata0;
            end
            if (state_q == ACCESS) begin
                rdata_q <= bus.mem_rdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module : tb_dmem_arbiter
// Brief  : Scoreboard bench for dmem_arbiter with a 64-word memory model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        bit          port;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst;
    logic init_mem;
    int   cyc;
    int   n_checks;
    int   n_fail;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    exp_t        exp_q   [$];

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign bus.mem_rdata = mem[bus.mem_addr[5:0]];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= (i == 9) ? 32'h11 : 32'h1000 + i;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Scoreboard: every ack pops the oldest expected completion
    always @(negedge clk) begin
        if (!rst && (bus.ack0 || bus.ack1)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ack_port", {62'd0, bus.ack1, bus.ack0}, e.port ? 64'd2 : 64'd1);
                check("rdata", bus.rdata, e.data);
            end
        end
    end

    task automatic push_exp(input bit port, input logic [31:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0; bus.lock1 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    endtask

    task automatic set_port(input bit port, input bit we, input logic [31:0] a, input logic [31:0] d);
        if (port) begin
            bus.req1 = 1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.req0 = 1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end
    endtask

    // Single access from IDLE with cycle-exact latency checks
    task automatic access(input bit port, input bit we, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        set_port(port, we, a, d);
        push_exp(port, ref_mem[a[5:0]]);
        if (we) ref_mem[a[5:0]] = d;
        @(posedge clk); #1;
        check("acc_mem_we", bus.mem_we, we);
        check("acc_mem_addr", bus.mem_addr, a);
        @(posedge clk); #1;
        check("ack_latency", port ? bus.ack1 : bus.ack0, 1);
        check("done_mem_we", bus.mem_we, 0);
        if (port) bus.req1 = 0; else bus.req0 = 0;
        @(posedge clk);
    endtask

    task automatic wait_ack(output int at);
        at = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("ack_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int t;
        int prev;
        cyc = 0; n_checks = 0; n_fail = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = (i == 9) ? 32'h11 : 32'h1000 + i;
        idle_inputs();
        rst = 1'b1;
        init_mem = 1'b1;
        #1;
        check("rst_ack0", bus.ack0, 0);
        check("rst_ack1", bus.ack1, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        @(posedge clk); @(negedge clk);
        init_mem = 1'b0;
        do_reset();

        // Write then read back on port 0
        access(0, 1, 32'd5, 32'hDEADBEEF);
        access(0, 0, 32'd5, 32'h0);

        // Continuous contention, no lock: alternation starting with port 0
        do_reset();
        @(negedge clk);
        set_port(0, 0, 32'd3, 0);
        set_port(1, 0, 32'd7, 0);
        for (int k = 0; k < 4; k++) push_exp(k[0], ref_mem[(k % 2 == 1) ? 7 : 3]);
        prev = -1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(t);
            if (k > 0) check("ack_spacing", t - prev, 3);
            prev = t;
        end
        bus.req0 = 0; bus.req1 = 0;
        @(posedge clk);

        // Lock burst: one fair P1 grant, eight locked, then fairness, then lock off
        do_reset();
        access(0, 0, 32'd3, 0);
        @(negedge clk);
        bus.lock1 = 1;
        set_port(0, 0, 32'd3, 0);
        set_port(1, 0, 32'd7, 0);
        for (int k = 0; k < 9; k++) push_exp(1, ref_mem[7]);
        push_exp(0, ref_mem[3]);
        push_exp(1, ref_mem[7]);
        push_exp(0, ref_mem[3]);
        push_exp(1, ref_mem[7]);
        for (int k = 0; k < 13; k++) begin
            wait_ack(t);
            if (k == 9) bus.lock1 = 0;
        end
        bus.req0 = 0; bus.req1 = 0;
        @(posedge clk);

        // Read-before-write on port 1
        access(1, 1, 32'd9, 32'h22);
        access(1, 0, 32'd9, 32'h0);

        // Reset in the middle of a write access
        @(negedge clk);
        set_port(1, 1, 32'd20, 32'hCAFEF00D);
        @(posedge clk); #1;
        check("mid_mem_we_pre", bus.mem_we, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_mem_we", bus.mem_we, 0);
        check("mid_busy", bus.busy, 0);
        check("mid_ack", {bus.ack1, bus.ack0}, 0);
        check("mid_mem_addr", bus.mem_addr, 0);
        check("mid_mem_wdata", bus.mem_wdata, 0);
        check("mid_rdata", bus.rdata, 0);
        bus.req1 = 0; bus.we1 = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        check("mid_mem_unchanged", mem[20], ref_mem[20]);

        // Port 1 request arriving during DONE of a port-0 access
        @(negedge clk);
        set_port(0, 0, 32'd3, 0);
        push_exp(0, ref_mem[3]);
        push_exp(1, ref_mem[7]);
        @(posedge clk); @(posedge clk); #1;
        check("late_ack0", bus.ack0, 1);
        bus.req0 = 0;
        set_port(1, 0, 32'd7, 0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            check("late_no_dup_ack0", bus.ack0, 0);
            check("late_ack1_timing", bus.ack1, (k == 3) ? 1 : 0);
        end
        bus.req1 = 0;
        repeat (3) @(posedge clk);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the single-port 64-word data memory. Port 0 serves the core's load/store unit and port 1 serves a secondary master (debug/DMA loader). The block performs fair round-robin selection, latches the winning request, drives one memory access, and returns read data with a one-cycle acknowledge. Port 1 may lock the memory for short bursts. The block sits between the requesters and the memory's address, write-data, write-enable and read-data pins.

## Interface
- `AW`, default 32: address width, passed through unmodified (word index).
- `DW`, default 32: data width.
- `MAX_LOCK`, default 8: maximum consecutive port-1 grants while `lock1` is held.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req0` / `req1` input 1: access request; held until the matching ack.
- `we0` / `we1` input 1: 1 = write, 0 = read; valid while req is high.
- `addr0` / `addr1` input AW: word address.
- `wdata0` / `wdata1` input DW: write data.
- `lock1` input 1: port 1 requests bus lock for a burst.
- `ack0` / `ack1` output 1: one-cycle completion pulse.
- `rdata` output DW: registered read data; valid when either ack is high.
- `mem_addr` output AW: to the memory address pin.
- `mem_wdata` output DW: to the memory write-data pin.
- `mem_we` output 1: to the memory write enable (MemRW).
- `mem_rdata` input DW: combinational read data from the memory.
- `busy` output 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCESS, DONE.
  - IDLE → ACCESS when `req0 | req1`. Latches the winner index, `we`, `addr` and `wdata` into internal registers.
  - ACCESS → DONE unconditionally. Captures `mem_rdata` into `rdata` at the exit edge.
  - DONE → IDLE unconditionally. Raises the ack of the served port and ignores requests in this state.
- Selection in IDLE:
  - Only one port requesting: that port wins.
  - Both requesting: the port not granted last wins. Exception: a lock is active, in which case port 1 wins.
  - `last_grant` updates on every IDLE→ACCESS transition.
- Lock:
  - A lock is active when `lock1` is high, the last grant was port 1, and `lock_cnt < MAX_LOCK`.
  - `lock_cnt` increments on each port-1 grant taken while a lock is active.
  - `lock_cnt` clears on any port-0 grant or whenever `lock1` is low.
  - At `MAX_LOCK`, fairness resumes, so port 0 wins the next tie.
- Memory drive:
  - `mem_addr` and `mem_wdata` come from the latched registers in ACCESS and are 0 otherwise.
  - `mem_we` = latched `we` AND (state == ACCESS), decoded from the state register.
- Writes return read-before-write data in `rdata`, i.e. the old content of the word.
- Requester contract: drop `req` or present a new request in the cycle after the ack. Fields must stay stable from req assertion through the ack.

## Timing
- Reset values:
  - state = IDLE, `last_grant` = 1 (port 0 wins the first tie), `lock_cnt` = 0.
  - `ack0`, `ack1`, `busy`, `mem_we` = 0; `rdata`, `mem_addr`, `mem_wdata` = 0.
- Latency: request sampled in IDLE at edge N gives ACCESS in cycle N+1 and ack in cycle N+2.
- Throughput: one access per 3 cycles.
- `mem_we` is high for exactly one cycle per write and never outside ACCESS.
- A request arriving during ACCESS or DONE waits. The other port's request pending in DONE is served from the next IDLE.
- Reset mid-operation: state returns to IDLE immediately and asynchronously, `mem_we` falls without waiting for the clock, the latched access is discarded, and no ack is produced.
- Width rules:
  - `lock_cnt` is `$clog2(MAX_LOCK+1)` bits and saturates at `MAX_LOCK`.
  - Addresses are not range-checked; the memory decodes word indices 0–63.

## Structure
- Shared package/include `dmem_arb_pkg` holds:
  - state encodings: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2;
  - port indices: P0=1'b0, P1=1'b1.
- Sub-module `rr_pick2`: combinational 2-way round-robin picker with inputs (`req0`, `req1`, `last`, `force1`) and outputs (`valid`, `winner`).
- The FSM, lock counter and latches stay in `dmem_arbiter`.

## Test plan
- Reset, then `req0` write addr=5 wdata=0xDEADBEEF: `mem_we` is high for 1 cycle in cycle 1, `ack0` in cycle 2; a subsequent `req0` read of addr=5 returns `rdata`=0xDEADBEEF with `ack0` 2 cycles after sampling.
- `req0` and `req1` both asserted continuously (reads, addrs 3 and 7) from reset: grants alternate P0, P1, P0, P1, with one ack every 3 cycles; `rdata` matches each address.
- `lock1`=1 with `req0` and `req1` always high, `MAX_LOCK`=8: port 1 receives 9 consecutive grants (the initial grant plus 8 locked), then port 0 is granted; dropping `lock1` restores alternation.
- Write to addr 9 (old value 0x11, new value 0x22): `rdata` at ack = 0x11, and a following read returns 0x22.
- Assert `rst` during ACCESS of a write: `mem_we` drops within the same cycle, no ack is issued, the memory word is unchanged, and all outputs read 0.
- `req1` arrives during DONE of a port-0 access: `ack1` appears exactly 3 cycles after DONE (IDLE, ACCESS, DONE), and port 0 gets no duplicate ack.
